calc_sequencer: RTL and testbench
=================================

CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 SHALL have parameter W, default 6, operand width in bits.
REQ-002 SHALL have parameter NOPS, default 6, operands per job.
REQ-003 SHALL have parameter OW, default 10, result width in bits.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port start  input  1  job request; sampled only in IDLE.
REQ-007 SHALL have port mode  input  2  operation select; latched when start is accepted.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port in_data  input  W  operand stream.
REQ-010 SHALL have port in_valid  input  1  in_data valid.
REQ-011 SHALL have port in_ready  output  1  high only in LOAD.
REQ-012 SHALL have port out_data  output  OW  job result.
REQ-013 SHALL have port out_valid  output  1  out_data valid; high only in DONE.
REQ-014 SHALL have port out_ready  input  1  consumer accepts out_data.

Function
REQ-015 SHALL use FSM states IDLE, LOAD, CALC, DONE.
REQ-016 IDLE: start=1 latches mode, clears the operand counter, and moves to LOAD next cycle.
REQ-017 LOAD: each cycle with in_valid&in_ready SHALL write in_data into buffer slot cnt and increment cnt.
- Bubbles (in_valid=0) stall without side effects.
- After slot NOPS-1 is written: cnt clears and the FSM moves to CALC.
REQ-018 CALC: SHALL process one buffered operand per cycle, index 0..NOPS-1, through the shared ALU step.
- Takes exactly NOPS cycles, then moves to DONE.
REQ-019 DONE: SHALL hold out_data and out_valid=1 stable until out_ready=1.
- On the out_ready cycle it returns to IDLE; out_valid is low the following cycle.
REQ-020 Accumulator init at first CALC cycle, by mode:
- 00 sum: acc=0; acc+=op.
- 01 max: acc=op0; acc=max(acc,op).
- 10 min: acc=op0; acc=min(acc,op).
- 11 alternating: even-index operands added, odd-index subtracted; internal width OW+1 signed; final result clamped to 0 if negative.
REQ-021 All results SHALL be zero-extended to OW bits; mode 00 maximum is NOPS*(2^W-1)=378 for the defaults and never overflows.
REQ-022 start asserted while busy SHALL be ignored; mode changes after acceptance SHALL NOT affect the running job.
REQ-023 Minimum latency from start accepted to out_valid SHALL be 1+NOPS+NOPS cycles (13 with the defaults) when in_valid is held high.
REQ-024 start and out_ready both high in DONE SHALL return to IDLE only; the new start is taken no earlier than the next cycle.

Reset
REQ-025 rst_n=0 SHALL immediately force: state=IDLE, cnt=0, acc=0, latched mode=00, busy=0, in_ready=0, out_valid=0, out_data=0.
- Holds regardless of clk, including mid-LOAD and mid-CALC; the partial job is discarded.
REQ-026 Operand buffer contents need not be reset; they SHALL NOT be observable before being rewritten.

Structure
REQ-027 Shared package calc_pkg SHALL hold mode encodings (MODE_SUM, MODE_MAX, MODE_MIN, MODE_ALT), FSM state encoding, and default W/NOPS/OW constants.
REQ-028 The accumulate step SHALL be one combinational sub-module, calc_alu.
- Inputs: acc, op, mode, first, odd.
- Output: next acc.
- Instantiated once.

Verification
REQ-029 Bench SHALL cover, after reset, mode 00 with operands 27,11,10,5,3,1 and in_valid held high.
- Required: out_data=57, out_valid first high 13 cycles after start.
REQ-030 Bench SHALL cover mode 01 with operands 27,11,10,5,3,1 and mode 10 with the same operands.
- Required: mode 01 gives 27; mode 10 gives 1.
REQ-031 Bench SHALL cover mode 11 with operands 27,11,10,5,3,1, then with 0,63,0,63,0,63.
- Required: 27-11+10-5+3-1=23; second set clamps to 0.
REQ-032 Bench SHALL cover mode 00 with all operands 63 plus in_valid bubbles between beats, and out_ready low for 5 cycles.
- Required: out_data=378 held stable, out_valid held high until out_ready.
REQ-033 Bench SHALL cover rst_n pulsed low during CALC, then a fresh job with mode 01 and operands 1..6.
- Required: all outputs 0 immediately on reset; the new job returns 6.
REQ-034 Bench SHALL cover start pulsed with mode=10 while busy on a mode-00 job.
- Required: the pulse is ignored and the result matches mode 00.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calc_sequencer block: default sizes, mode
// encodings and the controller state encoding.
package calc_pkg;

  localparam int DEF_W    = 6;
  localparam int DEF_NOPS = 6;
  localparam int DEF_OW   = 10;

  localparam logic [1:0] MODE_SUM = 2'b00;
  localparam logic [1:0] MODE_MAX = 2'b01;
  localparam logic [1:0] MODE_MIN = 2'b10;
  localparam logic [1:0] MODE_ALT = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/calc_alu.sv
// Combinational accumulate step shared by every mode: folds one operand into
// the running accumulator.
module calc_alu
  import calc_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int OW = DEF_OW
) (
  input  logic signed [OW:0]  acc,
  input  logic        [W-1:0] op,
  input  logic        [1:0]   mode,
  input  logic                first,
  input  logic                odd,
  output logic signed [OW:0]  acc_next
);

  logic signed [OW:0] op_ext;

  always_comb begin
    op_ext   = $signed({{(OW + 1 - W){1'b0}}, op});
    acc_next = acc;
    // Operand 0 seeds every mode: 0+op for sum, op0 for max/min, +op0 for alt.
    if (first) begin
      acc_next = op_ext;
    end else begin
      case (mode)
        MODE_SUM: acc_next = acc + op_ext;
        MODE_MAX: if (op_ext > acc) acc_next = op_ext;
        MODE_MIN: if (op_ext < acc) acc_next = op_ext;
        default:  acc_next = odd ? (acc - op_ext) : (acc + op_ext);
      endcase
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Job sequencer: captures NOPS operands into a local buffer, folds them one per
// cycle through calc_alu, then presents the result until it is accepted.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int NOPS = DEF_NOPS,
  parameter int OW   = DEF_OW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    mode,
  output logic          busy,
  input  logic [W-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [OW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam int CW = (NOPS > 1) ? $clog2(NOPS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NOPS - 1);

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic signed [OW:0] acc_q, acc_d;
  logic [1:0]         mode_q, mode_d;
  logic               mem_we;
  logic signed [OW:0] alu_next;
  logic [W-1:0]       op_mem_q [NOPS];

  // Only the alternating mode can go negative; everything else passes through.
  function automatic logic [OW-1:0] clamp_result(input logic signed [OW:0] a);
    if (a < 0) return '0;
    return a[OW-1:0];
  endfunction

  calc_alu #(
    .W  (W),
    .OW (OW)
  ) u_alu (
    .acc      (acc_q),
    .op       (op_mem_q[cnt_q]),
    .mode     (mode_q),
    .first    (cnt_q == '0),
    .odd      (cnt_q[0]),
    .acc_next (alu_next)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mode_d  = mode_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mode;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (in_valid) begin
          mem_we = 1'b1;
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = CALC;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      CALC: begin
        acc_d = alu_next;
        if (cnt_q == LAST_IDX) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        // A start seen here is deliberately not taken; IDLE samples it next.
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mode_q  <= MODE_SUM;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mode_q  <= mode_d;
    end
  end

  // Operand storage is never read before a full load, so it carries no reset.
  always_ff @(posedge clk) begin
    if (mem_we) op_mem_q[cnt_q] <= in_data;
  end

  assign busy      = (state_q != IDLE);
  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_valid ? clamp_result(acc_q) : '0;

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: jobs push their expected result when
// driven, and each scenario pops and compares when out_valid appears.
module tb_calc_sequencer;

  localparam int W    = 6;
  localparam int NOPS = 6;
  localparam int OW   = 10;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [1:0]    mode;
  logic          busy;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int t_start = 0;
  int sb_q[$];

  int ops_a[6]   = '{27, 11, 10, 5, 3, 1};
  int ops_alt[6] = '{0, 63, 0, 63, 0, 63};
  int ops_max[6] = '{63, 63, 63, 63, 63, 63};
  int ops_seq[6] = '{1, 2, 3, 4, 5, 6};

  calc_sequencer #(.W(W), .NOPS(NOPS), .OW(OW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .busy      (busy),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int model(input logic [1:0] m, input int ops[6]);
    int r;
    r = ops[0];
    for (int i = 1; i < 6; i++) begin
      case (m)
        2'b00: r = r + ops[i];
        2'b01: if (ops[i] > r) r = ops[i];
        2'b10: if (ops[i] < r) r = ops[i];
        default: r = (i % 2 == 1) ? r - ops[i] : r + ops[i];
      endcase
    end
    if (r < 0) r = 0;
    return r;
  endfunction

  // Entered and left just after a falling edge.
  task automatic drive_job(input logic [1:0] m, input int ops[6],
                           input bit bubbles, input bit busy_pulse);
    start   = 1'b1;
    mode    = m;
    t_start = cyc;
    sb_q.push_back(model(m, ops));
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bubbles) begin
        in_valid = 1'b0;
        in_data  = W'(i);
        @(negedge clk);
      end
      if (busy_pulse && i == 2) begin
        start = 1'b1;
        mode  = 2'b10;
      end
      in_data  = W'(ops[i]);
      in_valid = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    in_valid = 1'b0;
    if (busy_pulse) begin
      start = 1'b1;
      mode  = 2'b11;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic wait_result(output logic [OW-1:0] d, output int lat, output bit to);
    to = 1'b1;
    for (int k = 0; k < 64; k++) begin
      if (out_valid === 1'b1) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    d   = out_data;
    lat = cyc - t_start;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_vec++;
    if ({busy, in_ready, out_valid} !== 3'b000 || out_data !== '0) begin
      n_err++;
      $display("FAIL reset_async: busy/in_ready/out_valid=%b out_data=%0d, required 000 and 0",
               {busy, in_ready, out_valid}, out_data);
    end
    start = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, in_ready, out_valid} !== 3'b000 || out_data !== '0) begin
      n_err++;
      $display("FAIL reset_hold: busy/in_ready/out_valid=%b out_data=%0d, required 000 and 0",
               {busy, in_ready, out_valid}, out_data);
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: busy=%b required 0", busy);
    end
  endtask

  task automatic test_sum_latency();
    logic [OW-1:0] d;
    int lat, exp;
    bit to;
    drive_job(2'b00, ops_a, 1'b0, 1'b0);
    wait_result(d, lat, to);
    exp = sb_q.pop_front();
    n_vec++;
    if (to || d !== exp[OW-1:0]) begin
      n_err++;
      $display("FAIL sum_result: got %0d required %0d (timeout=%0d)", d, exp, to);
    end
    n_vec++;
    if (lat != 13) begin
      n_err++;
      $display("FAIL sum_latency: got %0d cycles required 13", lat);
    end
    release_result();
    n_vec++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL sum_release: out_valid=%b busy=%b required 0 0", out_valid, busy);
    end
  endtask

  task automatic test_max_min_alt();
    logic [OW-1:0] d;
    int lat, exp;
    bit to;
    logic [1:0] modes[4] = '{2'b01, 2'b10, 2'b11, 2'b11};
    for (int j = 0; j < 4; j++) begin
      drive_job(modes[j], (j == 3) ? ops_alt : ops_a, 1'b0, 1'b0);
      wait_result(d, lat, to);
      exp = sb_q.pop_front();
      n_vec++;
      if (to || d !== exp[OW-1:0]) begin
        n_err++;
        $display("FAIL mode%0d_job%0d: got %0d required %0d (timeout=%0d)",
                 modes[j], j, d, exp, to);
      end
      release_result();
    end
  endtask

  task automatic test_bubbles_backpressure();
    logic [OW-1:0] d;
    int lat, exp;
    bit to;
    drive_job(2'b00, ops_max, 1'b1, 1'b0);
    wait_result(d, lat, to);
    exp = sb_q.pop_front();
    n_vec++;
    if (to || d !== exp[OW-1:0]) begin
      n_err++;
      $display("FAIL bubble_sum: got %0d required %0d (timeout=%0d)", d, exp, to);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== exp[OW-1:0]) begin
        n_err++;
        $display("FAIL hold_cycle%0d: out_valid=%b out_data=%0d required 1 %0d",
                 k, out_valid, out_data, exp);
      end
    end
    release_result();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL hold_release: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_calc();
    logic [OW-1:0] d;
    int lat, exp;
    bit to;
    drive_job(2'b00, ops_a, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    void'(sb_q.pop_back());
    n_vec++;
    if ({busy, in_ready, out_valid} !== 3'b000 || out_data !== '0) begin
      n_err++;
      $display("FAIL reset_mid_calc: busy/in_ready/out_valid=%b out_data=%0d, required 000 and 0",
               {busy, in_ready, out_valid}, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_job(2'b01, ops_seq, 1'b0, 1'b0);
    wait_result(d, lat, to);
    exp = sb_q.pop_front();
    n_vec++;
    if (to || d !== exp[OW-1:0]) begin
      n_err++;
      $display("FAIL post_reset_job: got %0d required %0d (timeout=%0d)", d, exp, to);
    end
    release_result();
  endtask

  task automatic test_start_while_busy();
    logic [OW-1:0] d;
    int lat, exp;
    bit to;
    drive_job(2'b00, ops_a, 1'b0, 1'b1);
    wait_result(d, lat, to);
    exp = sb_q.pop_front();
    n_vec++;
    if (to || d !== exp[OW-1:0]) begin
      n_err++;
      $display("FAIL busy_start_result: got %0d required %0d (timeout=%0d)", d, exp, to);
    end
    release_result();
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL busy_start_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [OW-1:0] d;
    int lat, exp;
    bit to;
    drive_job(2'b10, ops_a, 1'b0, 1'b0);
    wait_result(d, lat, to);
    exp = sb_q.pop_front();
    n_vec++;
    if (to || d !== exp[OW-1:0]) begin
      n_err++;
      $display("FAIL b2b_first: got %0d required %0d (timeout=%0d)", d, exp, to);
    end
    out_ready = 1'b1;
    start     = 1'b1;
    mode      = 2'b00;
    @(negedge clk);
    out_ready = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_idle: busy=%b out_valid=%b required 0 0", busy, out_valid);
    end
    drive_job(2'b00, ops_a, 1'b0, 1'b0);
    wait_result(d, lat, to);
    exp = sb_q.pop_front();
    n_vec++;
    if (to || d !== exp[OW-1:0] || lat != 13) begin
      n_err++;
      $display("FAIL b2b_second: got %0d after %0d cycles required %0d after 13 (timeout=%0d)",
               d, lat, exp, to);
    end
    release_result();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    mode      = 2'b00;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_sum_latency();
    test_max_min_alt();
    test_bubbles_backpressure();
    test_reset_mid_calc();
    test_start_while_busy();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
